// File: rtl/mem_stage_ext_pkg.sv
// mem_stage_ext_pkg
//   Shared definitions for the memory-access stage:
//   - FSM state encoding
//   - load_op encodings
//   - XLEN-derived bus widths and exe_to_mem_bus field positions
//
// exe_to_mem_bus layout, MSB first:
//   {dst_load, dst_writeback, load_op[2:0], alu_result[XLEN], rd[5], pc[XLEN], ebreak}
package mem_stage_ext_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_WAIT  = 2'd2
  } mem_state_e;

  localparam logic [2:0] LOP_LB  = 3'b000;
  localparam logic [2:0] LOP_LH  = 3'b001;
  localparam logic [2:0] LOP_LW  = 3'b010;
  localparam logic [2:0] LOP_LD  = 3'b011;
  localparam logic [2:0] LOP_LBU = 3'b100;
  localparam logic [2:0] LOP_LHU = 3'b101;
  localparam logic [2:0] LOP_LWU = 3'b110;

  function automatic int eb_width(input int xlen);
    return 2 * xlen + 11;
  endfunction

  function automatic int wb_width(input int xlen);
    return 2 * xlen + 7;
  endfunction

  // LSB positions of the exe_to_mem_bus fields
  function automatic int eb_pc_lsb(input int xlen);
    return 1 + 0 * xlen;
  endfunction

  function automatic int eb_rd_lsb(input int xlen);
    return xlen + 1;
  endfunction

  function automatic int eb_alu_lsb(input int xlen);
    return xlen + 6;
  endfunction

  function automatic int eb_op_lsb(input int xlen);
    return 2 * xlen + 6;
  endfunction

  function automatic int eb_dwb_bit(input int xlen);
    return 2 * xlen + 9;
  endfunction

  function automatic int eb_load_bit(input int xlen);
    return 2 * xlen + 10;
  endfunction

endpackage

// File: rtl/mem_stage_ext_load_align.sv
// mem_stage_ext_load_align
//   Combinational sub-word load extraction: shifts the aligned read word
//   right by the byte offset, then sign/zero extends according to load_op.
//   Flags misaligned offsets and load_ops that are illegal for this XLEN
//   (illegal ops also force the result to zero).
//
// Ports:
//   raw      in  XLEN   aligned read word/doubleword
//   off      in  OFF_W  byte offset within the word
//   load_op  in  3      load encoding
//   result   out XLEN   extracted, extended value
//   ale      out 1      misaligned or illegal access
module mem_stage_ext_load_align
  import mem_stage_ext_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       load_op,
  output logic [XLEN-1:0]  result,
  output logic             ale
);

  typedef logic [XLEN-1:0] word_t;

  word_t shifted;

  assign shifted = raw >> {off, 3'b000};

  always_comb begin
    result = '0;
    ale    = 1'b0;
    case (load_op)
      LOP_LB:  result = word_t'($signed(shifted[7:0]));
      LOP_LBU: result = word_t'(shifted[7:0]);
      LOP_LH: begin
        result = word_t'($signed(shifted[15:0]));
        ale    = off[0];
      end
      LOP_LHU: begin
        result = word_t'(shifted[15:0]);
        ale    = off[0];
      end
      LOP_LW: begin
        result = word_t'($signed(shifted[31:0]));
        ale    = |off[1:0];
      end
      LOP_LWU: begin
        // lwu and ld only exist on a 64-bit datapath
        if (XLEN == 64) begin
          result = word_t'(shifted[31:0]);
          ale    = |off[1:0];
        end else begin
          ale = 1'b1;
        end
      end
      LOP_LD: begin
        if (XLEN == 64) begin
          result = shifted;
          ale    = |off;
        end else begin
          ale = 1'b1;
        end
      end
      default: ale = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_ext.sv
// mem_stage_ext
//   Memory-access pipeline stage between EXE and WB. Holds one instruction,
//   waits for the data-SRAM response of loads, buffers that response when WB
//   back-pressures, extracts/extends sub-word load data and drives the ID
//   forwarding path (including a load-pending interlock flag).
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   mem_allowin              out  stage can accept a new instruction
//   wb_allowin               in   WB can accept
//   exe_to_mem_valid/bus     in   instruction from EXE
//   data_sram_rvalid/rdata   in   load response (one pulse per load, in order)
//   mem_to_wb_valid/bus      out  {dst_writeback, rd, wb_result, pc, ebreak}
//   mem_ale                  out  misaligned/illegal load in MEM
//   mem_to_id_*              out  forwarding value, rd, write enable, load-pending
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no instruction held
// ST_BUSY  | non-load, or load whose data is held in buffer
// ST_WAIT  | load still waiting for its SRAM response
module mem_stage_ext
  import mem_stage_ext_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EB_W = 2 * XLEN + 11,
  parameter int WB_W = 2 * XLEN + 7
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_allowin,
  input  logic            wb_allowin,
  input  logic            exe_to_mem_valid,
  input  logic [EB_W-1:0] exe_to_mem_bus,
  input  logic            data_sram_rvalid,
  input  logic [XLEN-1:0] data_sram_rdata,
  output logic            mem_to_wb_valid,
  output logic [WB_W-1:0] mem_to_wb_bus,
  output logic            mem_ale,
  output logic [XLEN-1:0] mem_to_id_bypass,
  output logic [4:0]      mem_to_id_rdbypass,
  output logic            mem_to_id_rfwenbypass,
  output logic            mem_to_id_loadpending
);

  localparam int OFF_W    = $clog2(XLEN / 8);
  localparam int PC_LSB   = eb_pc_lsb(XLEN);
  localparam int RD_LSB   = eb_rd_lsb(XLEN);
  localparam int ALU_LSB  = eb_alu_lsb(XLEN);
  localparam int OP_LSB   = eb_op_lsb(XLEN);
  localparam int DWB_BIT  = eb_dwb_bit(XLEN);
  localparam int LOAD_BIT = eb_load_bit(XLEN);

  logic [EB_W-1:0] bus_q, bus_d;
  logic            mem_valid_q, mem_valid_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_q, buf_d;
  mem_state_e      state_q, state_d;

  logic            dst_load, dst_writeback, ebreak;
  logic [2:0]      load_op;
  logic [XLEN-1:0] alu_result, pc;
  logic [4:0]      rd;

  logic            ready_go, latch, retire, capture;
  logic [XLEN-1:0] raw, ld_result, wb_result;
  logic            align_ale;

  assign dst_load      = bus_q[LOAD_BIT];
  assign dst_writeback = bus_q[DWB_BIT];
  assign load_op       = bus_q[OP_LSB +: 3];
  assign alu_result    = bus_q[ALU_LSB +: XLEN];
  assign rd            = bus_q[RD_LSB +: 5];
  assign pc            = bus_q[PC_LSB +: XLEN];
  assign ebreak        = bus_q[0];

  // A buffered response means the load no longer depends on rvalid.
  assign ready_go    = !dst_load || buf_valid_q || data_sram_rvalid;
  assign mem_allowin = !mem_valid_q || (ready_go && wb_allowin);
  assign latch       = mem_allowin && exe_to_mem_valid;
  assign retire      = mem_to_wb_valid && wb_allowin;
  assign capture     = (state_q == ST_WAIT) && data_sram_rvalid && !wb_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      mem_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      bus_q       <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      buf_valid_q <= buf_valid_d;
      bus_q       <= bus_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    buf_valid_d = buf_valid_q;
    bus_d       = bus_q;
    buf_d       = buf_q;

    if (mem_allowin) mem_valid_d = exe_to_mem_valid;
    if (latch)       bus_d       = exe_to_mem_bus;
    if (capture) begin
      buf_d       = data_sram_rdata;
      buf_valid_d = 1'b1;
    end
    // The buffer belongs to the retiring load, never to its successor.
    if (retire) buf_valid_d = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (latch) state_d = exe_to_mem_bus[LOAD_BIT] ? ST_WAIT : ST_BUSY;
      end
      ST_BUSY: begin
        if (latch)       state_d = exe_to_mem_bus[LOAD_BIT] ? ST_WAIT : ST_BUSY;
        else if (retire) state_d = ST_EMPTY;
      end
      ST_WAIT: begin
        if (latch)        state_d = exe_to_mem_bus[LOAD_BIT] ? ST_WAIT : ST_BUSY;
        else if (retire)  state_d = ST_EMPTY;
        else if (capture) state_d = ST_BUSY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign raw = buf_valid_q ? buf_q : data_sram_rdata;

  mem_stage_ext_load_align #(
    .XLEN (XLEN),
    .OFF_W(OFF_W)
  ) u_load_align (
    .raw    (raw),
    .off    (alu_result[OFF_W-1:0]),
    .load_op(load_op),
    .result (ld_result),
    .ale    (align_ale)
  );

  assign wb_result = dst_load ? ld_result : alu_result;

  assign mem_to_wb_valid       = mem_valid_q && ready_go;
  assign mem_to_wb_bus         = {dst_writeback, rd, wb_result, pc, ebreak};
  assign mem_ale               = mem_valid_q && dst_load && align_ale;
  assign mem_to_id_bypass      = wb_result;
  assign mem_to_id_rdbypass    = rd;
  assign mem_to_id_rfwenbypass = dst_writeback && mem_valid_q;
  assign mem_to_id_loadpending = mem_valid_q && dst_load && !ready_go;

  // Responses arrive in order, so a load already holding buffered data can
  // never see another rvalid before it retires.
  always_ff @(posedge clk) begin
    if (!reset && mem_valid_q && buf_valid_q) begin
      assert (!data_sram_rvalid);
    end
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
module tb_mem_stage_ext;

  typedef struct packed {
    logic        load;
    logic        wb;
    logic [2:0]  op;
    logic [63:0] alu;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        ebreak;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        wb_allowin;
  logic        exe_to_mem_valid;
  logic        data_sram_rvalid;
  logic [63:0] rdata;
  ins_t        exe_ins;

  logic [74:0]  bus32;
  logic [138:0] bus64;
  assign bus32 = {exe_ins.load, exe_ins.wb, exe_ins.op, exe_ins.alu[31:0], exe_ins.rd,
                  exe_ins.pc[31:0], exe_ins.ebreak};
  assign bus64 = {exe_ins.load, exe_ins.wb, exe_ins.op, exe_ins.alu, exe_ins.rd,
                  exe_ins.pc, exe_ins.ebreak};

  logic        allowin32, v32, ale32, rfw32, lp32;
  logic [70:0] wbb32;
  logic [31:0] byp32;
  logic [4:0]  rdb32;

  logic         allowin64, v64, ale64, rfw64, lp64;
  logic [134:0] wbb64;
  logic [63:0]  byp64;
  logic [4:0]   rdb64;

  mem_stage_ext #(.XLEN(32)) dut32 (
    .clk                  (clk),
    .reset                (reset),
    .mem_allowin          (allowin32),
    .wb_allowin           (wb_allowin),
    .exe_to_mem_valid     (exe_to_mem_valid),
    .exe_to_mem_bus       (bus32),
    .data_sram_rvalid     (data_sram_rvalid),
    .data_sram_rdata      (rdata[31:0]),
    .mem_to_wb_valid      (v32),
    .mem_to_wb_bus        (wbb32),
    .mem_ale              (ale32),
    .mem_to_id_bypass     (byp32),
    .mem_to_id_rdbypass   (rdb32),
    .mem_to_id_rfwenbypass(rfw32),
    .mem_to_id_loadpending(lp32)
  );

  mem_stage_ext #(.XLEN(64)) dut64 (
    .clk                  (clk),
    .reset                (reset),
    .mem_allowin          (allowin64),
    .wb_allowin           (wb_allowin),
    .exe_to_mem_valid     (exe_to_mem_valid),
    .exe_to_mem_bus       (bus64),
    .data_sram_rvalid     (data_sram_rvalid),
    .data_sram_rdata      (rdata),
    .mem_to_wb_valid      (v64),
    .mem_to_wb_bus        (wbb64),
    .mem_ale              (ale64),
    .mem_to_id_bypass     (byp64),
    .mem_to_id_rdbypass   (rdb64),
    .mem_to_id_rfwenbypass(rfw64),
    .mem_to_id_loadpending(lp64)
  );

  // Reference model: the one instruction held in MEM and its load data, if any.
  logic        m_valid;
  ins_t        m_ins;
  logic        m_have;
  logic [63:0] m_data;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] trim(input int xlen, input logic [63:0] v);
    return (xlen == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  function automatic int byte_off(input int xlen, input ins_t i);
    return int'(i.alu % 64'(xlen / 8));
  endfunction

  function automatic logic [63:0] ld_value(input int xlen, input ins_t i, input logic [63:0] raw);
    logic [63:0] v;
    v = trim(xlen, raw) >> (8 * byte_off(xlen, i));
    case (i.op)
      3'd0:    v = {{56{v[7]}}, v[7:0]};
      3'd1:    v = {{48{v[15]}}, v[15:0]};
      3'd2:    v = {{32{v[31]}}, v[31:0]};
      3'd3:    v = (xlen == 64) ? v : 64'd0;
      3'd4:    v = {56'd0, v[7:0]};
      3'd5:    v = {48'd0, v[15:0]};
      3'd6:    v = (xlen == 64) ? {32'd0, v[31:0]} : 64'd0;
      default: v = 64'd0;
    endcase
    return trim(xlen, v);
  endfunction

  function automatic logic ld_ale(input int xlen, input ins_t i);
    int sz;
    case (i.op)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      3'd6:       sz = (xlen == 64) ? 4 : 0;
      3'd3:       sz = (xlen == 64) ? 8 : 0;
      default:    sz = 0;
    endcase
    if (sz == 0) return 1'b1;
    return (byte_off(xlen, i) % sz) != 0;
  endfunction

  function automatic ins_t mk(input logic load, input logic [2:0] op, input logic [63:0] alu);
    ins_t i;
    i.load   = load;
    i.wb     = 1'b1;
    i.op     = op;
    i.alu    = alu;
    i.rd     = alu[4:0] ^ 5'h11;
    i.pc     = 64'h8000_0000 + (alu << 2);
    i.ebreak = 1'b0;
    return i;
  endfunction

  task automatic check_side(input string s, input int xlen, input logic allowin, input logic v,
                            input logic ale, input logic rfw, input logic lp, input logic wbf,
                            input logic [4:0] rdf, input logic [63:0] res, input logic [63:0] pcf,
                            input logic ebf, input logic [63:0] byp, input logic [4:0] rdb);
    logic        ready;
    logic [63:0] exp_res;
    ready = !m_ins.load || m_have || data_sram_rvalid;
    chk({s, "_allowin"}, 64'(allowin), 64'(!m_valid || (ready && wb_allowin)));
    chk({s, "_valid"},   64'(v),       64'(m_valid && ready));
    chk({s, "_loadpend"}, 64'(lp),     64'(m_valid && m_ins.load && !ready));
    chk({s, "_rfwen"},   64'(rfw),     64'(m_valid && m_ins.wb));
    chk({s, "_ale"},     64'(ale),     64'(m_valid && m_ins.load && ld_ale(xlen, m_ins)));
    if (m_valid) begin
      exp_res = m_ins.load ? ld_value(xlen, m_ins, m_have ? m_data : rdata)
                           : trim(xlen, m_ins.alu);
      chk({s, "_bypass"}, byp, exp_res);
      chk({s, "_rdbyp"},  64'(rdb), 64'(m_ins.rd));
      if (m_valid && ready) begin
        chk({s, "_wbres"}, res, exp_res);
        chk({s, "_wbrd"},  64'(rdf), 64'(m_ins.rd));
        chk({s, "_wbdwb"}, 64'(wbf), 64'(m_ins.wb));
        chk({s, "_wbpc"},  pcf, trim(xlen, m_ins.pc));
        chk({s, "_wbebr"}, 64'(ebf), 64'(m_ins.ebreak));
      end
    end
  endtask

  // Drive one cycle at the falling edge, check, then advance the model to
  // what the stage should hold after the next rising edge.
  task automatic apply(input logic rst, input logic ev, input ins_t ins, input logic wb,
                       input logic rv, input logic [63:0] rd);
    logic ready;
    logic allow;
    @(negedge clk);
    reset            = rst;
    exe_to_mem_valid = ev;
    exe_ins          = ins;
    wb_allowin       = wb;
    data_sram_rvalid = rv;
    rdata            = rd;
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
    end else begin
      check_side("d32", 32, allowin32, v32, ale32, rfw32, lp32, wbb32[70], wbb32[69:65],
                 64'(wbb32[64:33]), 64'(wbb32[32:1]), wbb32[0], 64'(byp32), rdb32);
      check_side("d64", 64, allowin64, v64, ale64, rfw64, lp64, wbb64[134], wbb64[133:129],
                 wbb64[128:65], wbb64[64:1], wbb64[0], byp64, rdb64);
      ready = !m_ins.load || m_have || rv;
      allow = !m_valid || (ready && wb);
      if (m_valid && m_ins.load && !m_have && rv && !wb) begin
        m_have = 1'b1;
        m_data = rd;
      end
      if (m_valid && ready && wb) m_have = 1'b0;
      if (allow) begin
        m_valid = ev;
        m_ins   = ins;
      end
    end
  endtask

  initial begin
    ins_t        nop;
    ins_t        ri;
    logic        r_rst, r_ev, r_wb, r_rv;
    logic [63:0] r_rd;

    n_vec   = 0;
    n_err   = 0;
    m_valid = 1'b0;
    m_have  = 1'b0;
    m_ins   = '0;
    m_data  = '0;
    reset            = 1'b1;
    exe_to_mem_valid = 1'b0;
    exe_ins          = '0;
    wb_allowin       = 1'b0;
    data_sram_rvalid = 1'b0;
    rdata            = '0;
    nop = mk(1'b0, 3'd0, 64'd0);

    apply(1'b1, 1'b0, nop, 1'b0, 1'b0, 64'd0);
    apply(1'b1, 1'b0, nop, 1'b0, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("rst_valid",   64'(v32),       64'd0);
    chk("rst_allowin", 64'(allowin32), 64'd1);
    chk("rst_lp",      64'(lp64),      64'd0);
    chk("rst_rfwen",   64'(rfw32),     64'd0);

    // plain ALU op
    apply(1'b0, 1'b1, mk(1'b0, 3'd0, 64'h1234), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("alu_valid", 64'(v32), 64'd1);
    chk("alu_res",   64'(wbb32[64:33]), 64'h1234);
    chk("alu_lp",    64'(lp32), 64'd0);

    // lb at off 3, response two cycles late
    apply(1'b0, 1'b1, mk(1'b1, 3'd0, 64'h1003), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'h55);
    chk("lb_pend1", 64'(lp32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'h66);
    chk("lb_pend2", 64'(lp32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b1, 64'h80FF_FF00);
    chk("lb_valid", 64'(v32), 64'd1);
    chk("lb_res32", 64'(wbb32[64:33]), 64'hFFFF_FF80);
    chk("lb_res64", wbb64[128:65], 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ale",   64'(ale32), 64'd0);

    // lhu at off 2, WB stalls while the response arrives
    apply(1'b0, 1'b1, mk(1'b1, 3'd5, 64'h2002), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b0, 1'b1, 64'hBEEF_0000);
    chk("lhu_hold_valid", 64'(v32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b0, 1'b0, 64'h1111_2222);
    chk("lhu_buf_res", 64'(wbb32[64:33]), 64'h0000_BEEF);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'h3333_4444);
    chk("lhu_res",   64'(wbb32[64:33]), 64'h0000_BEEF);
    chk("lhu_valid", 64'(v32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("lhu_once", 64'(v32), 64'd0);

    // misaligned lw still flows through
    apply(1'b0, 1'b1, mk(1'b1, 3'd2, 64'h101), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b1, 64'hA1B2_C3D4);
    chk("lw_ale32", 64'(ale32), 64'd1);
    chk("lw_ale64", 64'(ale64), 64'd1);
    chk("lw_valid", 64'(v32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("lw_noblock", 64'(allowin32), 64'd1);

    // load then ALU op back to back
    apply(1'b0, 1'b1, mk(1'b1, 3'd2, 64'h200), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b1, mk(1'b0, 3'd0, 64'h55), 1'b1, 1'b1, 64'h0BAD_F00D);
    chk("b2b_allowin", 64'(allowin32), 64'd1);
    chk("b2b_ldvalid", 64'(v32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("b2b_aluvalid", 64'(v32), 64'd1);
    chk("b2b_alures",   64'(wbb32[64:33]), 64'h55);

    // reset while waiting, then a stray response
    apply(1'b0, 1'b1, mk(1'b1, 3'd0, 64'h300), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("wait_lp", 64'(lp32), 64'd1);
    apply(1'b1, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b1, 64'hFFFF_FFFF);
    chk("rstwait_valid32", 64'(v32), 64'd0);
    chk("rstwait_valid64", 64'(v64), 64'd0);
    chk("rstwait_allowin", 64'(allowin32), 64'd1);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b0, 64'd0);
    chk("rstwait_after", 64'(v32), 64'd0);

    // 64-bit lwu at off 4 and ld at off 0
    apply(1'b0, 1'b1, mk(1'b1, 3'd6, 64'h4004), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b1, 64'h8765_4321_0000_0000);
    chk("lwu64",     wbb64[128:65], 64'h0000_0000_8765_4321);
    chk("lwu64_ale", 64'(ale64), 64'd0);
    chk("lwu32_ale", 64'(ale32), 64'd1);
    apply(1'b0, 1'b1, mk(1'b1, 3'd3, 64'h4000), 1'b1, 1'b0, 64'd0);
    apply(1'b0, 1'b0, nop, 1'b1, 1'b1, 64'h8765_4321_0000_0000);
    chk("ld64",     wbb64[128:65], 64'h8765_4321_0000_0000);
    chk("ld64_ale", 64'(ale64), 64'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      r_rst     = ($urandom_range(0, 199) == 0);
      r_wb      = ($urandom_range(0, 3) != 0);
      r_ev      = ($urandom_range(0, 9) < 7);
      ri.load   = 1'($urandom_range(0, 1));
      ri.wb     = 1'($urandom_range(0, 1));
      ri.op     = 3'($urandom_range(0, 7));
      ri.alu    = {$urandom, $urandom};
      ri.rd     = 5'($urandom);
      ri.pc     = {$urandom, $urandom};
      ri.ebreak = 1'($urandom_range(0, 1));
      r_rd      = {$urandom, $urandom};
      if (m_valid && m_ins.load && !m_have)  r_rv = ($urandom_range(0, 9) < 4);
      else if (!m_valid || !m_ins.load)      r_rv = ($urandom_range(0, 9) == 0);
      else                                   r_rv = 1'b0;
      apply(r_rst, r_ev, ri, r_wb, r_rv, r_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
